packet_reduce: RTL and testbench
================================

Name: packet_reduce

Overview:
- Streaming reduction stage that sits directly downstream of the 4-bit vector source.
- Accepts a packet of WIDTH-bit words over a valid/ready handshake.
- Folds every accepted word into running AND/OR/XOR reduction flags.
- On the packet's last word, presents the six reduction results and a word count to a consumer over a second valid/ready handshake.

Parameters:
- WIDTH, 4, bits per input word (≥1).
- MAX_WORDS, 16, largest packet length counted exactly (≥1).
- CW, $clog2(MAX_WORDS+1), width of the word counter (derived localparam, not overridable).

Ports:
- clk  input  1  the block's single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word to fold.
- in_last  input  1  word is the final word of the packet; qualified by in_valid.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_and  output  1  AND-reduction over all bits of all packet words.
- out_nand  output  1  ~out_and.
- out_or  output  1  OR-reduction over the packet.
- out_nor  output  1  ~out_or.
- out_xor  output  1  XOR-reduction over the packet (1 = odd count of ones).
- out_xnor  output  1  ~out_xor (1 = even count of ones).
- out_count  output  CW  number of words in the packet (saturating).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Handshakes:
  - Transfer occurs on a rising edge where valid && ready.
  - in_ready and out_valid depend only on state, never combinationally on in_valid or out_ready.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accumulators: acc_and, acc_or, acc_xor, cnt.
  - Idle/cleared values: acc_and=1, acc_or=0, acc_xor=0, cnt=0.
- ACCUM, on input transfer:
  - acc_and <= acc_and & (&in_data)
  - acc_or <= acc_or | (|in_data)
  - acc_xor <= acc_xor ^ (^in_data)
  - cnt <= (cnt==MAX_WORDS) ? cnt : cnt+1
  - If in_last=1, go to HOLD; otherwise stay in ACCUM.
- Latency: out_valid rises on the clock after the last word's transfer. Accumulators and the state change update in the same edge.
- HOLD:
  - All outputs hold stable while out_ready=0.
  - On output transfer: go to ACCUM and clear the accumulators.
  - in_ready stays 0 in the transfer cycle; there is no same-cycle bypass.
  - Minimum gap between packets is one cycle.
- Outputs are driven directly from the accumulators:
  - out_and=acc_and, out_or=acc_or, out_xor=acc_xor, out_count=cnt.
  - out_nand, out_nor, out_xnor are the complements.
  - Outputs are meaningful only while out_valid=1.
- Reset:
  - Values after reset: state=ACCUM, accumulators cleared, out_valid=0.
  - in_ready=0 during any cycle where rst=1; the word is not accepted.
  - Reset mid-packet discards the partial packet.
  - Reset in HOLD drops the pending result; no output transfer occurs.
- Boundaries:
  - A single-word packet (in_last on the first word) is legal; cnt=1.
  - A word count beyond MAX_WORDS saturates cnt at MAX_WORDS; the reductions remain exact.
  - in_valid=0 in ACCUM leaves the accumulators unchanged.
  - in_last without in_valid is ignored.

Optional Feature:
- Macro: PACKET_REDUCE_OVF_EN.
- When defined:
  - Adds output port out_ovf (1 bit).
  - A sticky acc_ovf is set when a word is accepted while cnt==MAX_WORDS. It is cleared with the other accumulators and reset to 0.
  - out_ovf=acc_ovf, valid with out_valid.
- When undefined:
  - The port and register do not exist.
  - Saturation is silent.

Test Plan:
1. Reset, then single word 4'b0000 with last → next cycle out_valid=1: and=0 nand=1 or=0 nor=1 xor=0 xnor=1, count=1.
2. Packet 4'b0001, 4'b0010, 4'b0100 (last) with back-to-back valid → and=0 or=1 xor=1 xnor=0, count=3; out_valid exactly one cycle after the third transfer.
3. Packet 4'b1111, 4'b1111 (last) → and=1 nand=0 or=1 xor=0 xnor=1, count=2. Follow immediately with 4'b0011 (last): in_ready=0 in the output-transfer cycle, then the word is accepted; result and=0 or=1 xor=0, count=1.
4. Backpressure: after a result, out_ready=0 for 5 cycles → out_valid=1 and all outputs stable, in_ready=0 throughout; out_ready=1 → transfer, then in_ready=1 the next cycle.
5. Reset mid-packet:
   - Accept 4'b1010, 4'b0110 (no last), assert rst 1 cycle.
   - Then send 4'b1111 (last) → and=1 or=1 xor=0, count=1; no stale data.
6. MAX_WORDS=4, six words of 4'b0001 with last on the sixth → count=4, xor=0. With PACKET_REDUCE_OVF_EN: out_ovf=1, and 0 on the following 1-word packet. Without the macro: the build has no out_ovf port.

Source files
------------

// File: rtl/packet_reduce.sv
// Streaming AND/OR/XOR reduction over a valid/ready packet of WIDTH-bit words.
// Optional sticky count-overflow flag enabled by defining PACKET_REDUCE_OVF_EN.
module packet_reduce #(
    parameter  int WIDTH     = 4,
    parameter  int MAX_WORDS = 16,
    localparam int CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_and,
    output logic             out_nand,
    output logic             out_or,
    output logic             out_nor,
    output logic             out_xor,
    output logic             out_xnor,
`ifdef PACKET_REDUCE_OVF_EN
    output logic             out_ovf,
`endif
    output logic [CW-1:0]    out_count
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WORDS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    // Word-level reduction helpers.
    function automatic logic word_and(input logic [WIDTH-1:0] w);
        return &w;
    endfunction

    function automatic logic word_or(input logic [WIDTH-1:0] w);
        return |w;
    endfunction

    function automatic logic word_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    state_t          state_r;
    logic            acc_and_r;
    logic            acc_or_r;
    logic            acc_xor_r;
    logic [CW-1:0]   cnt_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            take_s;
    logic            at_max_s;
    logic [CW-1:0]   cnt_next_s;
`ifdef PACKET_REDUCE_OVF_EN
    logic            acc_ovf_r;
`endif

    // Input acceptance and saturating count step.
    always_comb begin
        take_s     = 1'b0;
        at_max_s   = 1'b0;
        cnt_next_s = cnt_r;
        if (in_valid && in_ready_r) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
        if (cnt_r == CNT_MAX) begin
            at_max_s   = 1'b1;
            cnt_next_s = cnt_r;
        end else begin
            at_max_s   = 1'b0;
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // Packet FSM with accumulators and registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ACCUM;
            acc_and_r   <= 1'b1;
            acc_or_r    <= 1'b0;
            acc_xor_r   <= 1'b0;
            cnt_r       <= CNT_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef PACKET_REDUCE_OVF_EN
            acc_ovf_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ACCUM: begin
                    if (take_s) begin
                        acc_and_r <= acc_and_r & word_and(in_data);
                        acc_or_r  <= acc_or_r | word_or(in_data);
                        acc_xor_r <= acc_xor_r ^ word_parity(in_data);
                        cnt_r     <= cnt_next_s;
`ifdef PACKET_REDUCE_OVF_EN
                        acc_ovf_r <= acc_ovf_r | at_max_s;
`endif
                        if (in_last) begin
                            state_r     <= HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Result leaves; clear for the next packet, no same-cycle accept.
                    if (out_ready) begin
                        state_r     <= ACCUM;
                        acc_and_r   <= 1'b1;
                        acc_or_r    <= 1'b0;
                        acc_xor_r   <= 1'b0;
                        cnt_r       <= CNT_ZERO;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
`ifdef PACKET_REDUCE_OVF_EN
                        acc_ovf_r   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_r     <= ACCUM;
                    acc_and_r   <= 1'b1;
                    acc_or_r    <= 1'b0;
                    acc_xor_r   <= 1'b0;
                    cnt_r       <= CNT_ZERO;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
`ifdef PACKET_REDUCE_OVF_EN
                    acc_ovf_r   <= 1'b0;
`endif
                end
            endcase
        end
    end

    // A word presented while reset is asserted must never look accepted.
    assign in_ready  = in_ready_r & ~rst;
    assign out_valid = out_valid_r;
    assign out_and   = acc_and_r;
    assign out_nand  = ~acc_and_r;
    assign out_or    = acc_or_r;
    assign out_nor   = ~acc_or_r;
    assign out_xor   = acc_xor_r;
    assign out_xnor  = ~acc_xor_r;
    assign out_count = cnt_r;
`ifdef PACKET_REDUCE_OVF_EN
    assign out_ovf   = acc_ovf_r;
`endif

endmodule

// File: tb/tb_packet_reduce.sv
// Self-checking bench for packet_reduce: table of packets plus hand-written
// backpressure and reset sequences; results checked through a scoreboard queue.
module tb_packet_reduce;

    localparam int W  = 4;
    localparam int MW = 4;
    localparam int CW = $clog2(MW + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic          out_and, out_nand, out_or, out_nor, out_xor, out_xnor;
    logic [CW-1:0] out_count;
`ifdef PACKET_REDUCE_OVF_EN
    logic          out_ovf;
`endif

    packet_reduce #(.WIDTH(W), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_and(out_and), .out_nand(out_nand), .out_or(out_or), .out_nor(out_nor),
        .out_xor(out_xor), .out_xnor(out_xnor),
`ifdef PACKET_REDUCE_OVF_EN
        .out_ovf(out_ovf),
`endif
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          e_and;
        logic          e_or;
        logic          e_xor;
        logic [CW-1:0] e_cnt;
        logic          e_ovf;
    } exp_t;

    typedef struct {
        int            n;
        logic [31:0]   w;
        int            idle;
        exp_t          e;
    } pkt_t;

    pkt_t tbl[9];
    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Scoreboard: compare each result on the cycle it is accepted downstream.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("and",   {31'd0, out_and},  {31'd0, e.e_and});
                chk("nand",  {31'd0, out_nand}, {31'd0, ~e.e_and});
                chk("or",    {31'd0, out_or},   {31'd0, e.e_or});
                chk("nor",   {31'd0, out_nor},  {31'd0, ~e.e_or});
                chk("xor",   {31'd0, out_xor},  {31'd0, e.e_xor});
                chk("xnor",  {31'd0, out_xnor}, {31'd0, ~e.e_xor});
                chk("count", 32'(out_count),    32'(e.e_cnt));
`ifdef PACKET_REDUCE_OVF_EN
                chk("ovf",   {31'd0, out_ovf},  {31'd0, e.e_ovf});
`endif
            end
        end
    end

    task automatic send_word(input logic [W-1:0] d, input logic last);
        int waitc;
        waitc = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waitc < 20) begin
            waitc++;
            @(negedge clk);
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        chk("out_valid_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_packet(input pkt_t p, input logic push);
        if (push) exp_q.push_back(p.e);
        for (int i = 0; i < p.n; i++) begin
            send_word(p.w[i*4 +: 4], (i == p.n - 1));
            if (i != p.n - 1) begin
                // Idle cycles carry a stray in_last that must be ignored.
                for (int k = 0; k < p.idle; k++) begin
                    in_last = 1'b1;
                    in_data = 4'b0000;
                    @(posedge clk);
                    #1;
                    in_last = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
        chk("in_ready_hold", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic set_pkt(input int idx, input int n, input logic [31:0] w, input int idle,
                           input logic a, input logic o, input logic x,
                           input logic [CW-1:0] c, input logic v);
        tbl[idx].n    = n;
        tbl[idx].w    = w;
        tbl[idx].idle = idle;
        tbl[idx].e    = '{e_and: a, e_or: o, e_xor: x, e_cnt: c, e_ovf: v};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t p;
        set_pkt(0, 1, 32'h00000000, 0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
        set_pkt(1, 3, 32'h00000421, 0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
        set_pkt(2, 2, 32'h000000FF, 0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
        set_pkt(3, 1, 32'h00000003, 0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
        set_pkt(4, 2, 32'h000000EF, 2, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0);
        set_pkt(5, 4, 32'h00000000, 0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0);
        set_pkt(6, 6, 32'h00111111, 0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1);
        set_pkt(7, 1, 32'h00000008, 0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0);
        set_pkt(8, 5, 32'h000FFFFF, 1, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1);

        rst = 1'b1; in_valid = 1'b1; in_data = 4'b1111; in_last = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_and", {31'd0, out_and}, 32'd1);
        chk("post_rst_count", 32'(out_count), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) send_packet(tbl[i], 1'b1);

        // Backpressure: result must hold for five stalled cycles.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        p.n = 1; p.w = 32'h0000000A; p.idle = 0;
        p.e = '{e_and: 1'b0, e_or: 1'b1, e_xor: 1'b0, e_cnt: 3'd1, e_ovf: 1'b0};
        send_packet(p, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_stable", {28'd0, out_and, out_or, out_xor, out_nand}, {28'd0, 4'b0101});
            chk("bp_count", 32'(out_count), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_after_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_after_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Reset mid-packet discards the partial packet.
        send_word(4'b1010, 1'b0);
        send_word(4'b0110, 1'b0);
        in_valid = 1'b1; in_data = 4'b1111; in_last = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        p.n = 1; p.w = 32'h0000000F; p.idle = 0;
        p.e = '{e_and: 1'b1, e_or: 1'b1, e_xor: 1'b0, e_cnt: 3'd1, e_ovf: 1'b0};
        send_packet(p, 1'b1);

        // Reset while holding a result drops it without a transfer.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        p.n = 1; p.w = 32'h00000005; p.idle = 0;
        send_packet(p, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("holdrst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        p.n = 1; p.w = 32'h00000001; p.idle = 0;
        p.e = '{e_and: 1'b0, e_or: 1'b1, e_xor: 1'b1, e_cnt: 3'd1, e_ovf: 1'b0};
        send_packet(p, 1'b1);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
